// File: rtl/br_resolve_unit.sv
// br_resolve_unit
// Execute-stage branch resolution: evaluates each control transfer against the
// fetch-time prediction, registers the verdict for fetch and the BPU, runs a
// short flush sequence after a misprediction and keeps saturating statistics.

module br_resolve_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  stall,
    input  logic                  ex_valid,
    input  logic                  ex_is_cond,
    input  logic                  ex_is_jal,
    input  logic                  ex_is_jalr,
    input  logic [2:0]            ex_funct3,
    input  logic [DATA_WIDTH-1:0] ex_pc,
    input  logic [DATA_WIDTH-1:0] ex_rs1,
    input  logic [DATA_WIDTH-1:0] ex_rs2,
    input  logic [DATA_WIDTH-1:0] ex_imm,
    input  logic                  ex_predict_taken,
    input  logic [DATA_WIDTH-1:0] ex_predict_pc,
    output logic                  br_taken,
    output logic [DATA_WIDTH-1:0] br_target,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  misprediction,
    output logic                  flush,
    output logic                  bpu_upd_valid,
    output logic [DATA_WIDTH-1:0] bpu_upd_pc,
    output logic [31:0]           branch_cnt,
    output logic [31:0]           mispredict_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // The flush counter counts down to zero, so it starts one below the
    // number of flush cycles; the first FLUSH cycle already counts.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    // JALR targets drop bit 0.
    localparam logic [DATA_WIDTH-1:0] LSB_CLEAR = {{(DATA_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [DATA_WIDTH-1:0] SEQ_STEP  = DATA_WIDTH'(4);

    state_t                state;
    state_t                state_next;
    logic [2:0]            flush_count;
    logic [2:0]            flush_count_next;

    logic                  is_ctrl;
    logic                  resolve;
    logic                  cond_taken;
    logic                  actual_taken;
    logic [DATA_WIDTH-1:0] pc_rel_target;
    logic [DATA_WIDTH-1:0] jalr_target;
    logic [DATA_WIDTH-1:0] actual_target;
    logic [DATA_WIDTH-1:0] seq_pc;
    logic                  dir_wrong;
    logic                  tgt_wrong;
    logic                  mispredict_now;

    logic [31:0]           br_count;
    logic [31:0]           mis_count;

    assign is_ctrl = ex_is_cond | ex_is_jal | ex_is_jalr;

    // Instructions arriving during a flush are on the wrong path, so only
    // an idle, unstalled unit accepts a resolve.
    assign resolve = ex_valid & is_ctrl & ~stall & (state == IDLE);

    // Condition evaluation for conditional branches; unused encodings fall through as not taken.
    always_comb begin
        cond_taken = 1'b0;
        case (ex_funct3)
            3'b000:  cond_taken = (ex_rs1 == ex_rs2);
            3'b001:  cond_taken = (ex_rs1 != ex_rs2);
            3'b100:  cond_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  cond_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  cond_taken = (ex_rs1 <  ex_rs2);
            3'b111:  cond_taken = (ex_rs1 >= ex_rs2);
            default: cond_taken = 1'b0;
        endcase
    end

    assign pc_rel_target = ex_pc + ex_imm;
    assign jalr_target   = (ex_rs1 + ex_imm) & LSB_CLEAR;
    assign seq_pc        = ex_pc + SEQ_STEP;

    // Actual direction and target; JALR takes priority over the PC-relative forms.
    always_comb begin
        actual_taken  = cond_taken;
        actual_target = pc_rel_target;
        if (ex_is_jalr) begin
            actual_taken  = 1'b1;
            actual_target = jalr_target;
        end else if (ex_is_jal) begin
            actual_taken  = 1'b1;
            actual_target = pc_rel_target;
        end
    end

    // A correct direction is not enough when taken: the predicted target must match too.
    assign dir_wrong      = (actual_taken != ex_predict_taken);
    assign tgt_wrong      = actual_taken & ex_predict_taken & (ex_predict_pc != actual_target);
    assign mispredict_now = dir_wrong | tgt_wrong;

    // Next-state logic for the flush sequencer.
    always_comb begin
        state_next       = state;
        flush_count_next = flush_count;
        case (state)
            IDLE: begin
                if (resolve && mispredict_now) begin
                    state_next       = FLUSH;
                    flush_count_next = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (!stall) begin
                    if (flush_count == 3'd0) begin
                        state_next = IDLE;
                    end else begin
                        flush_count_next = flush_count - 3'd1;
                    end
                end
            end
            default: begin
                state_next       = IDLE;
                flush_count_next = 3'd0;
            end
        endcase
    end

    // Flush sequencer state register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= IDLE;
            flush_count <= 3'd0;
        end else begin
            state       <= state_next;
            flush_count <= flush_count_next;
        end
    end

    // Single-cycle strobes are rewritten only on unstalled cycles so a stall holds them.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            misprediction <= 1'b0;
            bpu_upd_valid <= 1'b0;
        end else if (!stall) begin
            misprediction <= resolve & mispredict_now;
            bpu_upd_valid <= resolve & ~ex_is_jalr;
        end
    end

    // Resolution results hold their value until the next resolve.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            br_taken    <= 1'b0;
            br_target   <= '0;
            redirect_pc <= '0;
            bpu_upd_pc  <= '0;
        end else if (resolve) begin
            br_taken    <= actual_taken;
            br_target   <= actual_target;
            redirect_pc <= actual_taken ? actual_target : seq_pc;
            bpu_upd_pc  <= ex_pc;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            br_count  <= 32'd0;
            mis_count <= 32'd0;
        end else if (resolve) begin
            if (br_count != 32'hFFFF_FFFF) begin
                br_count <= br_count + 32'd1;
            end
            if (mispredict_now && (mis_count != 32'hFFFF_FFFF)) begin
                mis_count <= mis_count + 32'd1;
            end
        end
    end

    assign branch_cnt     = br_count;
    assign mispredict_cnt = mis_count;

    // The misprediction pulse coincides with the first FLUSH cycle, so the
    // squash covers exactly the cycles spent in FLUSH.
    assign flush = (state == FLUSH) | misprediction;

endmodule

// File: tb/tb_br_resolve_unit.sv
// Testbench for br_resolve_unit: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.

module tb_br_resolve_unit;

    localparam int FLUSH_N = 2;

    logic        clk;
    logic        arst;
    logic        stall;
    logic        ex_valid;
    logic        ex_is_cond;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic [31:0] ex_imm;
    logic        ex_predict_taken;
    logic [31:0] ex_predict_pc;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] redirect_pc;
    logic        misprediction;
    logic        flush;
    logic        bpu_upd_valid;
    logic [31:0] bpu_upd_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    int total;
    int bad;
    bit checking;

    // Model expectations for the outputs after the next edge.
    logic        e_taken;
    logic [31:0] e_target;
    logic [31:0] e_redirect;
    logic        e_mis;
    logic        e_flush;
    logic        e_bpu;
    logic [31:0] e_bpupc;
    logic [31:0] e_bcnt;
    logic [31:0] e_mcnt;
    int          flush_left;

    br_resolve_unit #(.DATA_WIDTH(32), .FLUSH_CYCLES(FLUSH_N)) dut (
        .clk              (clk),
        .arst             (arst),
        .stall            (stall),
        .ex_valid         (ex_valid),
        .ex_is_cond       (ex_is_cond),
        .ex_is_jal        (ex_is_jal),
        .ex_is_jalr       (ex_is_jalr),
        .ex_funct3        (ex_funct3),
        .ex_pc            (ex_pc),
        .ex_rs1           (ex_rs1),
        .ex_rs2           (ex_rs2),
        .ex_imm           (ex_imm),
        .ex_predict_taken (ex_predict_taken),
        .ex_predict_pc    (ex_predict_pc),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .redirect_pc      (redirect_pc),
        .misprediction    (misprediction),
        .flush            (flush),
        .bpu_upd_valid    (bpu_upd_valid),
        .bpu_upd_pc       (bpu_upd_pc),
        .branch_cnt       (branch_cnt),
        .mispredict_cnt   (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Architectural meaning of a control transfer, straight from the ISA rules.
    function automatic void ref_resolve(input int kind, input logic [2:0] f3,
                                        input logic [31:0] pc, input logic [31:0] rs1,
                                        input logic [31:0] rs2, input logic [31:0] imm,
                                        output logic taken, output logic [31:0] tgt);
        int signed a;
        int signed b;
        a = rs1;
        b = rs2;
        taken = 1'b0;
        tgt   = pc + imm;
        if (kind == 3) begin
            taken = 1'b1;
            tgt   = (rs1 + imm) & 32'hFFFF_FFFE;
        end else if (kind == 2) begin
            taken = 1'b1;
        end else begin
            case (f3)
                3'd0: taken = (rs1 == rs2);
                3'd1: taken = (rs1 != rs2);
                3'd4: taken = (a < b);
                3'd5: taken = (a >= b);
                3'd6: taken = (rs1 < rs2);
                3'd7: taken = (rs1 >= rs2);
                default: taken = 1'b0;
            endcase
        end
    endfunction

    task automatic model_reset();
        e_taken    = 1'b0;
        e_target   = '0;
        e_redirect = '0;
        e_mis      = 1'b0;
        e_flush    = 1'b0;
        e_bpu      = 1'b0;
        e_bpupc    = '0;
        e_bcnt     = '0;
        e_mcnt     = '0;
        flush_left = 0;
    endtask

    // Advances the model across the coming clock edge using the current inputs.
    task automatic model_step();
        int          kind;
        logic        taken;
        logic [31:0] tgt;
        bit          accept;
        bit          wrong;
        if (!stall) begin
            kind   = ex_is_jalr ? 3 : (ex_is_jal ? 2 : (ex_is_cond ? 1 : 0));
            accept = ex_valid && (kind != 0) && (flush_left == 0);
            e_mis  = 1'b0;
            e_bpu  = 1'b0;
            if (flush_left > 0) flush_left--;
            if (accept) begin
                ref_resolve(kind, ex_funct3, ex_pc, ex_rs1, ex_rs2, ex_imm, taken, tgt);
                wrong      = (taken != ex_predict_taken) || (taken && ex_predict_pc != tgt);
                e_taken    = taken;
                e_target   = tgt;
                e_redirect = taken ? tgt : ex_pc + 32'd4;
                e_bpupc    = ex_pc;
                e_bpu      = (kind != 3);
                e_mis      = wrong;
                if (e_bcnt != 32'hFFFF_FFFF) e_bcnt++;
                if (wrong) begin
                    if (e_mcnt != 32'hFFFF_FFFF) e_mcnt++;
                    flush_left = FLUSH_N;
                end
            end
            e_flush = (flush_left > 0);
        end
    endtask

    // Drives one cycle of inputs at a falling edge and returns at the next falling edge.
    task automatic applyStimulus(input bit v, input int kind, input logic [2:0] f3,
                                 input logic [31:0] pc, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic [31:0] imm,
                                 input bit pt, input logic [31:0] ppc, input bit st);
        ex_valid         = v;
        ex_is_cond       = (kind == 1);
        ex_is_jal        = (kind == 2);
        ex_is_jalr       = (kind == 3);
        ex_funct3        = f3;
        ex_pc            = pc;
        ex_rs1           = rs1;
        ex_rs2           = rs2;
        ex_imm           = imm;
        ex_predict_taken = pt;
        ex_predict_pc    = ppc;
        stall            = st;
        model_step();
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(posedge clk) begin
        #1;
        if (checking && !arst) begin
            checkOutput("br_taken",       32'(br_taken),      32'(e_taken));
            checkOutput("br_target",      br_target,          e_target);
            checkOutput("redirect_pc",    redirect_pc,        e_redirect);
            checkOutput("misprediction",  32'(misprediction), 32'(e_mis));
            checkOutput("flush",          32'(flush),         32'(e_flush));
            checkOutput("bpu_upd_valid",  32'(bpu_upd_valid), 32'(e_bpu));
            checkOutput("bpu_upd_pc",     bpu_upd_pc,         e_bpupc);
            checkOutput("branch_cnt",     branch_cnt,         e_bcnt);
            checkOutput("mispredict_cnt", mispredict_cnt,     e_mcnt);
        end
    end

    initial begin
        logic        rt;
        logic [31:0] rtgt;
        int          kind;
        int          pmode;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        bit          pt;
        logic [31:0] ppc;

        total    = 0;
        bad      = 0;
        checking = 0;
        arst     = 1'b1;
        stall    = 1'b0;
        ex_valid = 1'b0;
        ex_is_cond = 1'b0;
        ex_is_jal  = 1'b0;
        ex_is_jalr = 1'b0;
        ex_funct3  = 3'd0;
        ex_pc = '0; ex_rs1 = '0; ex_rs2 = '0; ex_imm = '0;
        ex_predict_taken = 1'b0;
        ex_predict_pc    = '0;
        model_reset();

        repeat (2) @(negedge clk);
        checkOutput("rst_br_taken",   32'(br_taken),      32'd0);
        checkOutput("rst_flush",      32'(flush),         32'd0);
        checkOutput("rst_mis",        32'(misprediction), 32'd0);
        checkOutput("rst_redirect",   redirect_pc,        32'd0);
        checkOutput("rst_branch_cnt", branch_cnt,         32'd0);
        arst     = 1'b0;
        checking = 1;

        $display("[TB] correct BEQ");
        applyStimulus(1, 1, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1, 32'h120, 0);
        checkOutput("beq_taken",  32'(br_taken),      32'd1);
        checkOutput("beq_target", br_target,          32'h120);
        checkOutput("beq_mis",    32'(misprediction), 32'd0);
        checkOutput("beq_bpu",    32'(bpu_upd_valid), 32'd1);
        checkOutput("beq_cnt",    branch_cnt,         32'd1);

        $display("[TB] BLT direction mispredict, BNE during flush");
        applyStimulus(1, 1, 3'd4, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40, 0, 32'h0, 0);
        checkOutput("blt_taken",  32'(br_taken),      32'd1);
        checkOutput("blt_target", br_target,          32'h340);
        checkOutput("blt_mis",    32'(misprediction), 32'd1);
        checkOutput("blt_flush1", 32'(flush),         32'd1);
        checkOutput("blt_mcnt",   mispredict_cnt,     32'd1);
        applyStimulus(1, 1, 3'd1, 32'h800, 32'd1, 32'd2, 32'h80, 0, 32'h0, 0);
        checkOutput("bne_flush2", 32'(flush),         32'd1);
        checkOutput("bne_mis",    32'(misprediction), 32'd0);
        checkOutput("bne_cnt",    branch_cnt,         32'd2);
        applyStimulus(1, 1, 3'd1, 32'h800, 32'd1, 32'd2, 32'h80, 0, 32'h0, 0);
        checkOutput("bne_last_flush", 32'(flush),     32'd0);
        checkOutput("bne_last_cnt",   branch_cnt,     32'd2);
        checkOutput("bne_target",     br_target,      32'h340);

        $display("[TB] BLTU not-taken mispredict");
        applyStimulus(1, 1, 3'd6, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 1, 32'h210, 0);
        checkOutput("bltu_taken",    32'(br_taken),      32'd0);
        checkOutput("bltu_redirect", redirect_pc,        32'h204);
        checkOutput("bltu_mis",      32'(misprediction), 32'd1);
        idleCycle();
        idleCycle();

        $display("[TB] JALR target");
        applyStimulus(1, 3, 3'd0, 32'h400, 32'h1003, 32'd0, 32'h4, 1, 32'h1006, 0);
        checkOutput("jalr_target", br_target,          32'h1006);
        checkOutput("jalr_mis",    32'(misprediction), 32'd0);
        checkOutput("jalr_bpu",    32'(bpu_upd_valid), 32'd0);
        checkOutput("jalr_bpupc",  bpu_upd_pc,         32'h400);

        $display("[TB] back-to-back JALs");
        applyStimulus(1, 2, 3'd0, 32'h500, 32'd0, 32'd0, 32'h100, 1, 32'h600, 0);
        checkOutput("jal1_cnt", branch_cnt, 32'd5);
        applyStimulus(1, 2, 3'd0, 32'h600, 32'd0, 32'd0, 32'hFFFF_FFF8, 1, 32'h5F8, 0);
        checkOutput("jal2_cnt",    branch_cnt,    32'd6);
        checkOutput("jal2_target", br_target,     32'h5F8);
        checkOutput("jal2_bpu",    32'(bpu_upd_valid), 32'd1);

        $display("[TB] stall during flush");
        applyStimulus(1, 1, 3'd0, 32'h700, 32'd1, 32'd2, 32'h10, 1, 32'h710, 0);
        checkOutput("stl_mis", 32'(misprediction), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 3'd1, 32'h900, 32'd1, 32'd2, 32'h10, 0, 32'h0, 1);
            checkOutput("stl_flush_held", 32'(flush),         32'd1);
            checkOutput("stl_mis_held",   32'(misprediction), 32'd1);
        end
        idleCycle();
        checkOutput("stl_flush_after", 32'(flush),         32'd1);
        checkOutput("stl_mis_after",   32'(misprediction), 32'd0);
        idleCycle();
        checkOutput("stl_flush_done",  32'(flush),         32'd0);
        checkOutput("stl_cnt",         branch_cnt,         32'd7);

        $display("[TB] reset mid-flush");
        applyStimulus(1, 2, 3'd0, 32'hA00, 32'd0, 32'd0, 32'h40, 0, 32'h0, 0);
        ex_valid = 1'b0;
        arst     = 1'b1;
        #1;
        checkOutput("ar_flush",  32'(flush),         32'd0);
        checkOutput("ar_mis",    32'(misprediction), 32'd0);
        checkOutput("ar_taken",  32'(br_taken),      32'd0);
        checkOutput("ar_target", br_target,          32'd0);
        checkOutput("ar_bcnt",   branch_cnt,         32'd0);
        checkOutput("ar_mcnt",   mispredict_cnt,     32'd0);
        model_reset();
        @(negedge clk);
        arst = 1'b0;

        $display("[TB] mispredict counter saturation");
        force dut.mis_count = 32'hFFFF_FFFF;
        release dut.mis_count;
        e_mcnt = 32'hFFFF_FFFF;
        applyStimulus(1, 1, 3'd0, 32'hB00, 32'd3, 32'd3, 32'h20, 0, 32'h0, 0);
        checkOutput("sat_mis",  32'(misprediction), 32'd1);
        checkOutput("sat_mcnt", mispredict_cnt,     32'hFFFF_FFFF);
        checkOutput("sat_bcnt", branch_cnt,         32'd1);
        idleCycle();
        idleCycle();

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            kind  = $urandom_range(0, 3);
            f3    = 3'($urandom_range(0, 7));
            pc    = $urandom & 32'hFFFF_FFFC;
            rs1   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            rs2   = ($urandom_range(0, 2) == 0) ? rs1 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom);
            imm   = 32'($signed(16'($urandom)));
            ref_resolve((kind == 0) ? 1 : kind, f3, pc, rs1, rs2, imm, rt, rtgt);
            pmode = $urandom_range(0, 2);
            pt    = rt;
            ppc   = rtgt;
            if (pmode == 1) pt = !rt;
            if (pmode == 2) ppc = rtgt + 32'd4;
            applyStimulus($urandom_range(0, 4) != 0, kind, f3, pc, rs1, rs2, imm, pt, ppc,
                          $urandom_range(0, 4) == 0);
        end
        idleCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/br_resolve_unit.md
# br_resolve_unit

Execute-stage branch resolution unit. It drives the redirect side of the fetch interface: `br_taken`, `br_target` and `misprediction`, plus a BPU training write. It evaluates each control-transfer instruction against the prediction carried down the pipe from fetch, and registers the verdict for the fetch stage and the BPU. A flush state machine squashes wrong-path instructions for a fixed number of cycles after each misprediction. Saturating branch and misprediction counters provide performance visibility.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand and PC width.
- `FLUSH_CYCLES`, 2, cycles that `flush` stays high after a misprediction (legal range 1–7).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `arst` in 1: reset, asynchronous, active-high.
- `stall` in 1: pipeline stall; freezes all state.
- `ex_valid` in 1: a valid instruction is in EX this cycle.
- `ex_is_cond` in 1: conditional branch.
- `ex_is_jal` in 1: JAL.
- `ex_is_jalr` in 1: JALR.
- `ex_funct3` in 3: branch condition code.
- `ex_pc` in DATA_WIDTH: PC of the EX instruction.
- `ex_rs1` in DATA_WIDTH: forwarded operand 1.
- `ex_rs2` in DATA_WIDTH: forwarded operand 2.
- `ex_imm` in DATA_WIDTH: sign-extended immediate.
- `ex_predict_taken` in 1: fetch-time taken prediction.
- `ex_predict_pc` in DATA_WIDTH: fetch-time predicted target.
- `br_taken` out 1: registered actual direction.
- `br_target` out DATA_WIDTH: registered actual taken target.
- `redirect_pc` out DATA_WIDTH: registered correct next PC.
- `misprediction` out 1: registered, one-cycle pulse.
- `flush` out 1: squash the IF/ID and ID/EX registers.
- `bpu_upd_valid` out 1: one-cycle BPU training strobe.
- `bpu_upd_pc` out DATA_WIDTH: PC of the resolved branch.
- `branch_cnt` out 32: number of resolved control transfers.
- `mispredict_cnt` out 32: number of mispredictions.

## Operation
- Resolve condition: `ex_valid & (ex_is_cond | ex_is_jal | ex_is_jalr) & ~stall & state==IDLE`.
- Conditional branch direction, by `ex_funct3`:
  - 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU.
  - 010 and 011 resolve as not taken.
- JAL and JALR are always taken.
- Target:
  - Conditional branch and JAL: `ex_pc + ex_imm`.
  - JALR: `(ex_rs1 + ex_imm) & ~1`.
  - Additions wrap modulo 2^DATA_WIDTH.
- `redirect_pc` = target if taken, otherwise `ex_pc + 4`.
- A misprediction is declared when either:
  - actual taken ≠ `ex_predict_taken`, or
  - actual taken is 1, `ex_predict_taken` is 1, and `ex_predict_pc` ≠ target.
- JAL and JALR use the same rule.
- FSM states:
  - IDLE → FLUSH on a resolve that mispredicts; the flush counter loads FLUSH_CYCLES−1.
  - FLUSH: the counter decrements each non-stalled cycle; at 0, return to IDLE.
- `flush` = (state==FLUSH) combined with the registered `misprediction` pulse. It is high for exactly FLUSH_CYCLES non-stalled cycles, starting the cycle `misprediction` rises.
- In FLUSH, `ex_valid` instructions are wrong-path. They are ignored: no outputs, no counts, no BPU update.
- Counters:
  - `branch_cnt` increments on every resolve.
  - `mispredict_cnt` increments on every misprediction.
  - Both saturate at 0xFFFF_FFFF.
- `bpu_upd_valid` pulses on every resolve of a conditional branch or JAL. It does not pulse for JALR, because the BPU does not learn indirect targets.
- Stall freezes the FSM, counters and all output registers. Pulse outputs stay held while stalled; they are consumed only when `stall` is low.

## Timing
- Latency: outputs are valid on the cycle after the resolving edge.
  - `misprediction`, `bpu_upd_valid`: single-cycle pulses.
  - `br_taken`, `br_target`, `redirect_pc`, `bpu_upd_pc`: hold until the next resolve.
- Reset (`arst` high, asynchronous):
  - All outputs are 0; state is IDLE; counters are 0.
  - Reset may occur mid-FLUSH; `flush` drops immediately.
- Back-to-back resolves in IDLE with correct predictions are accepted every cycle.
- A resolve coinciding with the last FLUSH cycle is ignored.
- If a resolve arrives while `stall` is high, it is taken on the first non-stalled cycle, provided `ex_valid` is still high.

## Test plan
- Correct prediction:
  - Stimulus: BEQ with pc=0x100, rs1=rs2=5, imm=0x20, predict_taken=1, predict_pc=0x120.
  - Next cycle: `br_taken`=1, `br_target`=0x120, `misprediction`=0, `bpu_upd_valid`=1, `branch_cnt`=1.
- Direction misprediction:
  - Stimulus: BLT with rs1=0xFFFF_FFFF, rs2=1, predict_taken=0.
  - Response: taken, `misprediction` pulses, `flush` high for 2 cycles.
  - A valid BNE presented during the flush yields no output change and no count.
- Not-taken misprediction:
  - Stimulus: BLTU with the same operands, pc=0x200, predict_taken=1.
  - Response: `br_taken`=0, `redirect_pc`=0x204, `misprediction`=1.
- JALR target:
  - Stimulus: rs1=0x1003, imm=0x4, predict_taken=1, predict_pc=0x1006.
  - Response: `br_target`=0x1006, no misprediction, `bpu_upd_valid`=0.
- Stall and reset:
  - Stall held for 3 cycles during FLUSH: `flush` is held and the counter frozen; after release, 1 more flush cycle.
  - `arst` pulsed mid-FLUSH: all outputs 0 and state IDLE asynchronously.
- Saturation: force `mispredict_cnt` to 0xFFFF_FFFF (hierarchical deposit), then cause a misprediction; the value stays 0xFFFF_FFFF.
